// File: rtl/btn_press_classifier.sv
// Classifies debounced button gestures into single click, double click and long press.
// Emits registered one-cycle event pulses, a held flag for long presses, and a busy flag.
module btn_press_classifier #(
    parameter int LONG_TICKS = 25_000_000,
    parameter int DBL_TICKS  = 12_500_000,
    parameter int CW         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic db_level,
    input  logic db_tick,
    output logic click_tick,
    output logic dbl_tick,
    output logic long_tick,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_TICKS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          lvl_d;
    logic          release_ev;
    logic          click_nxt;
    logic          dbl_nxt;
    logic          long_nxt;
    logic          held_nxt;
    logic          busy_nxt;

    // lvl_d resets low so a level already high at reset never yields a release in a live state
    assign release_ev = lvl_d & ~db_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lvl_d      <= 1'b0;
            click_tick <= 1'b0;
            dbl_tick   <= 1'b0;
            long_tick  <= 1'b0;
            held       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lvl_d      <= db_level;
            click_tick <= click_nxt;
            dbl_tick   <= dbl_nxt;
            long_tick  <= long_nxt;
            held       <= held_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
                if (db_tick) begin
                    state_nxt = PRESS1;
                    cnt_nxt   = '0;
                end
            end
            PRESS1: begin
                state_nxt = PRESS1;
                cnt_nxt   = cnt + CW'(1);
                // release beats a coincident terminal count: short press
                if (release_ev) begin
                    state_nxt = WAIT2;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG;
                end
            end
            LONG: begin
                state_nxt = release_ev ? IDLE : LONG;
            end
            WAIT2: begin
                state_nxt = WAIT2;
                cnt_nxt   = cnt + CW'(1);
                if (db_tick) begin
                    state_nxt = PRESS2;
                end else if (cnt == DBL_LAST) begin
                    state_nxt = IDLE;
                end
            end
            PRESS2: begin
                state_nxt = release_ev ? IDLE : PRESS2;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        click_nxt = 1'b0;
        dbl_nxt   = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            PRESS1: long_nxt = ~release_ev & (cnt == LONG_LAST);
            WAIT2: begin
                dbl_nxt   = db_tick;
                click_nxt = ~db_tick & (cnt == DBL_LAST);
            end
            default: begin
                click_nxt = 1'b0;
                dbl_nxt   = 1'b0;
                long_nxt  = 1'b0;
            end
        endcase
        held_nxt = (state_nxt == LONG);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier: gesture schedules produce expected output timelines
// from the timing rules, then directed and random gestures are replayed and compared per cycle.
module tb_btn_press_classifier;

    localparam int LT = 8;
    localparam int DT = 6;
    localparam int CW = 4;
    localparam int N  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic db_level = 1'b0;
    logic db_tick = 1'b0;
    logic click_tick, dbl_tick, long_tick, held, busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit s_lvl [N];
    bit s_tck [N];
    bit e_click [N];
    bit e_dbl [N];
    bit e_long [N];
    bit e_held [N];
    bit e_busy [N];

    btn_press_classifier #(.LONG_TICKS(LT), .DBL_TICKS(DT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .db_level(db_level), .db_tick(db_tick),
        .click_tick(click_tick), .dbl_tick(dbl_tick), .long_tick(long_tick),
        .held(held), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            s_lvl[i] = 0; s_tck[i] = 0;
            e_click[i] = 0; e_dbl[i] = 0; e_long[i] = 0; e_held[i] = 0; e_busy[i] = 0;
        end
    endtask

    // Drive one cycle's inputs, let edge happen, return 1 time unit after it.
    task automatic step(input bit l, input bit t);
        @(negedge clk);
        db_level = l;
        db_tick  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; db_level = 1'b0; db_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Gesture: tick sampled at edge p, level high for h cycles, release sampled at r = p+h+1.
    // k in 1..DT puts a second tick at r+k held h2 cycles; otherwise no second press.
    task automatic add_gesture(input int p, input int h, input int k, input int h2, output int nxt);
        int r, q, r2;
        s_tck[p] = 1;
        for (int i = p + 1; i <= p + h; i++) s_lvl[i] = 1;
        r = p + h + 1;
        for (int i = p; i < r; i++) e_busy[i] = 1;
        if (h >= LT) begin
            e_long[p + LT] = 1;
            for (int i = p + LT; i < r; i++) e_held[i] = 1;
            nxt = r + 1;
        end else if (k >= 1 && k <= DT) begin
            q = r + k;
            s_tck[q] = 1;
            e_dbl[q] = 1;
            for (int i = q + 1; i <= q + h2; i++) s_lvl[i] = 1;
            r2 = q + h2 + 1;
            for (int i = r; i < r2; i++) e_busy[i] = 1;
            nxt = r2 + 1;
        end else begin
            e_click[r + DT] = 1;
            for (int i = r; i < r + DT; i++) e_busy[i] = 1;
            nxt = r + DT + 1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; db_level = 1'b1; db_tick = 1'b0;
        #1;
        n_checks++;
        if ({click_tick, dbl_tick, long_tick, held, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_vals got=%b exp=%b", {click_tick, dbl_tick, long_tick, held, busy}, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step(c < 5, 1'b0);
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_held_level cyc=%0d got=%b exp=%b", c,
                         {click_tick, dbl_tick, long_tick, held, busy}, 5'b0);
            end
        end
    endtask

    task automatic test_click();
        int nxt, n_click, at;
        do_reset();
        clear_sched();
        add_gesture(2, 3, 0, 0, nxt);
        n_click = 0; at = -1;
        for (int c = 0; c < nxt + 4; c++) begin
            step(s_lvl[c], s_tck[c]);
            if (click_tick) begin n_click++; at = c; end
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !==
                {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]}) begin
                n_fail++;
                $display("FAIL click cyc=%0d got=%b exp=%b", c, {click_tick, dbl_tick, long_tick, held, busy},
                         {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]});
            end
        end
        n_checks++;
        if (n_click !== 1 || at !== 12) begin
            n_fail++;
            $display("FAIL click_count got=%0d@%0d exp=1@12", n_click, at);
        end
    endtask

    task automatic test_double();
        int nxt, n_click, n_dbl, at;
        do_reset();
        clear_sched();
        add_gesture(2, 3, 2, 4, nxt);
        n_click = 0; n_dbl = 0; at = -1;
        for (int c = 0; c < nxt + 10; c++) begin
            step(s_lvl[c], s_tck[c]);
            if (click_tick) n_click++;
            if (dbl_tick) begin n_dbl++; at = c; end
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !==
                {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]}) begin
                n_fail++;
                $display("FAIL double cyc=%0d got=%b exp=%b", c, {click_tick, dbl_tick, long_tick, held, busy},
                         {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]});
            end
        end
        n_checks++;
        if (n_dbl !== 1 || n_click !== 0 || at !== 8) begin
            n_fail++;
            $display("FAIL double_count got dbl=%0d@%0d click=%0d exp dbl=1@8 click=0", n_dbl, at, n_click);
        end
    endtask

    task automatic test_long();
        int nxt, n_long, n_click, at, n_held;
        do_reset();
        clear_sched();
        add_gesture(2, 20, 0, 0, nxt);
        n_long = 0; n_click = 0; at = -1; n_held = 0;
        for (int c = 0; c < nxt + 10; c++) begin
            step(s_lvl[c], s_tck[c]);
            if (long_tick) begin n_long++; at = c; end
            if (click_tick) n_click++;
            if (held) n_held++;
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !==
                {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]}) begin
                n_fail++;
                $display("FAIL long cyc=%0d got=%b exp=%b", c, {click_tick, dbl_tick, long_tick, held, busy},
                         {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]});
            end
        end
        n_checks++;
        if (n_long !== 1 || at !== 10 || n_click !== 0 || n_held !== 13) begin
            n_fail++;
            $display("FAIL long_count got long=%0d@%0d click=%0d held=%0d exp long=1@10 click=0 held=13",
                     n_long, at, n_click, n_held);
        end
    endtask

    task automatic test_boundaries();
        int p, n_long, n_click, n_dbl;
        do_reset();
        clear_sched();
        add_gesture(1, LT - 1, 0, 0, p);   // release on cnt == LT-1
        add_gesture(p + 1, LT, 0, 0, p);   // one cycle longer: long press
        add_gesture(p + 1, 2, DT, 3, p);   // second press on last window cycle
        add_gesture(p + 1, 2, DT + 1, 0, p); // one cycle too late: click
        n_long = 0; n_click = 0; n_dbl = 0;
        for (int c = 0; c < p + 4; c++) begin
            step(s_lvl[c], s_tck[c]);
            if (long_tick) n_long++;
            if (click_tick) n_click++;
            if (dbl_tick) n_dbl++;
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !==
                {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]}) begin
                n_fail++;
                $display("FAIL boundary cyc=%0d got=%b exp=%b", c, {click_tick, dbl_tick, long_tick, held, busy},
                         {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]});
            end
        end
        n_checks++;
        if (n_long !== 1 || n_click !== 2 || n_dbl !== 1) begin
            n_fail++;
            $display("FAIL boundary_count got long=%0d click=%0d dbl=%0d exp 1 2 1", n_long, n_click, n_dbl);
        end
    endtask

    task automatic test_rst_mid();
        int nxt;
        do_reset();
        clear_sched();
        add_gesture(1, 3, 0, 0, nxt);  // release sampled at edge 5
        for (int c = 0; c <= 7; c++) begin
            step(s_lvl[c], s_tck[c]);
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !==
                {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]}) begin
                n_fail++;
                $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", c, {click_tick, dbl_tick, long_tick, held, busy},
                         {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]});
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({click_tick, dbl_tick, long_tick, held, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_immediate got=%b exp=%b", {click_tick, dbl_tick, long_tick, held, busy}, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !== 5'b0) begin
                n_fail++;
                $display("FAIL rst_mid_after cyc=%0d got=%b exp=%b", c,
                         {click_tick, dbl_tick, long_tick, held, busy}, 5'b0);
            end
        end
    endtask

    task automatic test_random();
        int p, h, k, h2;
        do_reset();
        clear_sched();
        p = 2;
        while (p < N - 60) begin
            h  = $urandom_range(1, 14);
            k  = $urandom_range(1, DT + 3);
            h2 = $urandom_range(1, 12);
            add_gesture(p, h, k, h2, p);
            p = p + $urandom_range(0, 3);
        end
        for (int c = 0; c < p + 8; c++) begin
            step(s_lvl[c], s_tck[c]);
            n_checks++;
            if ({click_tick, dbl_tick, long_tick, held, busy} !==
                {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, {click_tick, dbl_tick, long_tick, held, busy},
                         {e_click[c], e_dbl[c], e_long[c], e_held[c], e_busy[c]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_double();
        test_long();
        test_boundaries();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
